// File: rtl/sumsq_arbiter.sv
// rtl/sumsq_arbiter.sv - two-channel round-robin arbiter sharing one registered (x+y)^2 datapath
// Optional SUMSQ_ARB_PIPE_EN adds an S_MUL stage that registers the sum before squaring.
module sumsq_arbiter #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           dav_a_,
  input  logic [N-1:0]   xa,
  input  logic [N-1:0]   ya,
  output logic           rfd_a,
  input  logic           dav_b_,
  input  logic [N-1:0]   xb,
  input  logic [N-1:0]   yb,
  output logic           rfd_b,
  output logic           dav_,
  output logic [2*N+1:0] q,
  output logic           id,
  input  logic           rfd
);

`ifdef SUMSQ_ARB_PIPE_EN
  typedef enum logic [2:0] {S_IDLE, S_REL, S_MUL, S_OUT, S_END} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REL, S_OUT, S_END} state_t;
`endif

  state_t         state, state_n;
  logic           sel, sel_n;
  logic           ptr, ptr_n;
  logic [N-1:0]   x, x_n, y, y_n;
  logic [2*N+1:0] q_n;
  logic           id_n, dav_n, rfd_a_n, rfd_b_n;
`ifdef SUMSQ_ARB_PIPE_EN
  logic [N:0]     s, s_n;
`endif

  logic           req_a, req_b, grant, released;
  logic [N:0]     sum;
  logic [2*N+1:0] sum_ext, sq;

  assign req_a    = ~dav_a_;
  assign req_b    = ~dav_b_;
  // A lone requester always wins; PTR only breaks ties.
  assign grant    = (req_a & req_b) ? ptr : req_b;
  assign released = sel ? dav_b_ : dav_a_;
  assign sum      = {1'b0, x} + {1'b0, y};
`ifdef SUMSQ_ARB_PIPE_EN
  assign sum_ext  = {{(N+1){1'b0}}, s};
`else
  assign sum_ext  = {{(N+1){1'b0}}, sum};
`endif
  assign sq       = sum_ext * sum_ext;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req_a | req_b) state_n = S_REL;
`ifdef SUMSQ_ARB_PIPE_EN
      S_REL:  if (released) state_n = S_MUL;
      S_MUL:  state_n = S_OUT;
`else
      S_REL:  if (released) state_n = S_OUT;
`endif
      S_OUT:  if (!rfd) state_n = S_END;
      S_END:  if (rfd) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    sel_n   = sel;
    ptr_n   = ptr;
    x_n     = x;
    y_n     = y;
    q_n     = q;
    id_n    = id;
    dav_n   = dav_;
    rfd_a_n = rfd_a;
    rfd_b_n = rfd_b;
`ifdef SUMSQ_ARB_PIPE_EN
    s_n     = s;
`endif
    case (state)
      S_IDLE: begin
        if (req_a | req_b) begin
          sel_n = grant;
          x_n   = grant ? xb : xa;
          y_n   = grant ? yb : ya;
          if (grant) rfd_b_n = 1'b0;
          else       rfd_a_n = 1'b0;
        end
      end
      S_REL: begin
        if (released) begin
          if (sel) rfd_b_n = 1'b1;
          else     rfd_a_n = 1'b1;
`ifdef SUMSQ_ARB_PIPE_EN
          s_n = sum;
`else
          q_n   = sq;
          id_n  = sel;
          dav_n = 1'b0;
`endif
        end
      end
`ifdef SUMSQ_ARB_PIPE_EN
      S_MUL: begin
        q_n   = sq;
        id_n  = sel;
        dav_n = 1'b0;
      end
`endif
      S_OUT: if (!rfd) dav_n = 1'b1;
      S_END: if (rfd) ptr_n = ~sel;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel   <= 1'b0;
      ptr   <= 1'b0;
      x     <= '0;
      y     <= '0;
      q     <= '0;
      id    <= 1'b0;
      dav_  <= 1'b1;
      rfd_a <= 1'b1;
      rfd_b <= 1'b1;
`ifdef SUMSQ_ARB_PIPE_EN
      s     <= '0;
`endif
    end else begin
      sel   <= sel_n;
      ptr   <= ptr_n;
      x     <= x_n;
      y     <= y_n;
      q     <= q_n;
      id    <= id_n;
      dav_  <= dav_n;
      rfd_a <= rfd_a_n;
      rfd_b <= rfd_b_n;
`ifdef SUMSQ_ARB_PIPE_EN
      s     <= s_n;
`endif
    end
  end

endmodule
